// File: rtl/unidade_controle_multiciclo.sv
// Multicycle RISC-V control unit: Moore FSM sequencing lw, sw, R, I, beq, jal.
// Also drives ALU control, immediate select, a retired counter and an error flag.
module unidade_controle_multiciclo #(
  parameter int LARGURA_CONTADOR = 32
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [6:0]                  opcode,
  input  logic [2:0]                  funct3,
  input  logic                        funct7_5,
  input  logic                        zero,
  output logic                        pc_escrita,
  output logic                        ir_escrita,
  output logic                        selecao_endereco,
  output logic                        mem_escrita,
  output logic                        reg_escrita,
  output logic [1:0]                  selecao_resultado,
  output logic [1:0]                  selecao_ula_a,
  output logic [1:0]                  selecao_ula_b,
  output logic [2:0]                  controle_ula,
  output logic [1:0]                  selecao_imediato,
  output logic [3:0]                  estado,
  output logic                        instrucao_invalida,
  output logic [LARGURA_CONTADOR-1:0] contador_instrucoes
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  typedef enum logic [3:0] {
    BUSCA           = 4'd0,
    DECODIFICA      = 4'd1,
    END_MEM         = 4'd2,
    LE_MEM          = 4'd3,
    ESCREVE_MEM_REG = 4'd4,
    ESCREVE_MEM     = 4'd5,
    EXEC_R          = 4'd6,
    ESCREVE_ULA     = 4'd7,
    EXEC_I          = 4'd8,
    JAL             = 4'd9,
    BEQ             = 4'd10,
    ERRO            = 4'd11
  } estado_t;

  estado_t    estado_atual;
  estado_t    proximo;
  logic [1:0] aluop;
  logic       pc_update;
  logic       branch;
  logic       retira;

  assign estado = estado_atual;

  // Retirement happens in the last state of each instruction path.
  assign retira = (estado_atual == ESCREVE_MEM_REG) ||
                  (estado_atual == ESCREVE_MEM) ||
                  (estado_atual == ESCREVE_ULA) ||
                  (estado_atual == BEQ);

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_atual        <= BUSCA;
      instrucao_invalida  <= 1'b0;
      contador_instrucoes <= '0;
    end else begin
      estado_atual <= proximo;
      if (proximo == ERRO)
        instrucao_invalida <= 1'b1;
      if (retira)
        contador_instrucoes <= contador_instrucoes
                               + LARGURA_CONTADOR'(1);
    end
  end

  always_comb begin
    proximo           = ERRO;
    ir_escrita        = 1'b0;
    selecao_endereco  = 1'b0;
    mem_escrita       = 1'b0;
    reg_escrita       = 1'b0;
    selecao_resultado = 2'b00;
    selecao_ula_a     = 2'b00;
    selecao_ula_b     = 2'b00;
    aluop             = 2'b00;
    pc_update         = 1'b0;
    branch            = 1'b0;
    case (estado_atual)
      BUSCA: begin
        ir_escrita        = 1'b1;
        selecao_ula_b     = 2'b10;
        selecao_resultado = 2'b10;
        pc_update         = 1'b1;
        proximo           = DECODIFICA;
      end
      DECODIFICA: begin
        selecao_ula_a = 2'b01;
        selecao_ula_b = 2'b01;
        unique case (1'b1)
          (opcode == OP_LW),
          (opcode == OP_SW):  proximo = END_MEM;
          (opcode == OP_R):   proximo = EXEC_R;
          (opcode == OP_I):   proximo = EXEC_I;
          (opcode == OP_JAL): proximo = JAL;
          (opcode == OP_BEQ): proximo = BEQ;
          default:            proximo = ERRO;
        endcase
      end
      END_MEM: begin
        selecao_ula_a = 2'b10;
        selecao_ula_b = 2'b01;
        proximo       = (opcode == OP_LW) ? LE_MEM : ESCREVE_MEM;
      end
      LE_MEM: begin
        selecao_endereco = 1'b1;
        proximo          = ESCREVE_MEM_REG;
      end
      ESCREVE_MEM_REG: begin
        selecao_resultado = 2'b01;
        reg_escrita       = 1'b1;
        proximo           = BUSCA;
      end
      ESCREVE_MEM: begin
        selecao_endereco = 1'b1;
        mem_escrita      = 1'b1;
        proximo          = BUSCA;
      end
      EXEC_R: begin
        selecao_ula_a = 2'b10;
        aluop         = 2'b10;
        proximo       = ESCREVE_ULA;
      end
      ESCREVE_ULA: begin
        reg_escrita = 1'b1;
        proximo     = BUSCA;
      end
      EXEC_I: begin
        selecao_ula_a = 2'b10;
        selecao_ula_b = 2'b01;
        aluop         = 2'b10;
        proximo       = ESCREVE_ULA;
      end
      JAL: begin
        selecao_ula_a = 2'b01;
        selecao_ula_b = 2'b10;
        pc_update     = 1'b1;
        proximo       = ESCREVE_ULA;
      end
      BEQ: begin
        selecao_ula_a = 2'b10;
        aluop         = 2'b01;
        branch        = 1'b1;
        proximo       = BUSCA;
      end
      ERRO:    proximo = ERRO;
      default: proximo = ERRO;
    endcase
  end

  assign pc_escrita = pc_update | (branch & zero);

  // Only R-type (opcode[5]=1) can turn funct3=000 into a subtraction.
  always_comb begin
    controle_ula = 3'b000;
    case (aluop)
      2'b00: controle_ula = 3'b000;
      2'b01: controle_ula = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:
            controle_ula = ({opcode[5], funct7_5} == 2'b11)
                           ? 3'b001 : 3'b000;
          3'b010:  controle_ula = 3'b101;
          3'b110:  controle_ula = 3'b011;
          3'b111:  controle_ula = 3'b010;
          default: controle_ula = 3'b000;
        endcase
      end
      default: controle_ula = 3'b000;
    endcase
  end

  always_comb begin
    selecao_imediato = 2'b00;
    unique case (1'b1)
      (opcode == OP_SW):  selecao_imediato = 2'b01;
      (opcode == OP_BEQ): selecao_imediato = 2'b10;
      (opcode == OP_JAL): selecao_imediato = 2'b11;
      default:            selecao_imediato = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Bench for the multicycle control unit: per-instruction state paths and outputs
// against a table model, plus a 4-bit counter instance for wraparound.
module tb_unidade_controle_multiciclo;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] BAD = 7'b1111111;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  opcode = 7'd0;
  logic [2:0]  funct3 = 3'd0;
  logic        funct7_5 = 1'b0;
  logic        zero = 1'b0;

  logic        pc_escrita, ir_escrita, selecao_endereco;
  logic        mem_escrita, reg_escrita, instrucao_invalida;
  logic [1:0]  selecao_resultado, selecao_ula_a, selecao_ula_b;
  logic [1:0]  selecao_imediato;
  logic [2:0]  controle_ula;
  logic [3:0]  estado;
  logic [31:0] contador_instrucoes;

  logic        w_pc, w_ir, w_se, w_me, w_re, w_inv;
  logic [1:0]  w_sr, w_ua, w_ub, w_si;
  logic [2:0]  w_cu;
  logic [3:0]  w_est;
  logic [3:0]  w_cnt;

  int checks = 0;
  int errors = 0;
  int cnt_model = 0;

  always #5 clock = ~clock;

  unidade_controle_multiciclo u_dut (
    .clock(clock), .reset(reset), .opcode(opcode),
    .funct3(funct3), .funct7_5(funct7_5), .zero(zero),
    .pc_escrita(pc_escrita), .ir_escrita(ir_escrita),
    .selecao_endereco(selecao_endereco),
    .mem_escrita(mem_escrita), .reg_escrita(reg_escrita),
    .selecao_resultado(selecao_resultado),
    .selecao_ula_a(selecao_ula_a), .selecao_ula_b(selecao_ula_b),
    .controle_ula(controle_ula),
    .selecao_imediato(selecao_imediato), .estado(estado),
    .instrucao_invalida(instrucao_invalida),
    .contador_instrucoes(contador_instrucoes)
  );

  unidade_controle_multiciclo #(.LARGURA_CONTADOR(4)) u_w (
    .clock(clock), .reset(reset), .opcode(opcode),
    .funct3(funct3), .funct7_5(funct7_5), .zero(zero),
    .pc_escrita(w_pc), .ir_escrita(w_ir),
    .selecao_endereco(w_se), .mem_escrita(w_me),
    .reg_escrita(w_re), .selecao_resultado(w_sr),
    .selecao_ula_a(w_ua), .selecao_ula_b(w_ub),
    .controle_ula(w_cu), .selecao_imediato(w_si),
    .estado(w_est), .instrucao_invalida(w_inv),
    .contador_instrucoes(w_cnt)
  );

  logic [16:0] obs;
  assign obs = {pc_escrita, ir_escrita, selecao_endereco, mem_escrita,
                reg_escrita, selecao_resultado, selecao_ula_a,
                selecao_ula_b, controle_ula, selecao_imediato,
                instrucao_invalida};

  // Operation the instruction means, not how the decoder derives it.
  function automatic logic [2:0] alu_sem(input logic [6:0] op,
                                         input logic [2:0] f3,
                                         input logic f7);
    case (f3)
      3'd0:    return (op == RT && f7) ? 3'b001 : 3'b000;
      3'd2:    return 3'b101;
      3'd6:    return 3'b011;
      3'd7:    return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [16:0] expect_out(input int s,
                                             input logic [6:0] op,
                                             input logic [2:0] f3,
                                             input logic f7,
                                             input logic z);
    logic pc, ir, se, me, re, inv;
    logic [1:0] sr, ua, ub, si;
    logic [2:0] cu;
    pc = 0; ir = 0; se = 0; me = 0; re = 0; inv = 0;
    sr = 0; ua = 0; ub = 0; cu = 0;
    si = (op == SW) ? 2'd1 : (op == BQ) ? 2'd2 :
         (op == JL) ? 2'd3 : 2'd0;
    case (s)
      0:  begin ir = 1; ub = 2; sr = 2; pc = 1; end
      1:  begin ua = 1; ub = 1; end
      2:  begin ua = 2; ub = 1; end
      3:  se = 1;
      4:  begin sr = 1; re = 1; end
      5:  begin se = 1; me = 1; end
      6:  begin ua = 2; cu = alu_sem(op, f3, f7); end
      7:  re = 1;
      8:  begin ua = 2; ub = 1; cu = alu_sem(op, f3, f7); end
      9:  begin ua = 1; ub = 2; pc = 1; end
      10: begin ua = 2; cu = 3'b001; pc = z; end
      default: inv = 1;
    endcase
    return {pc, ir, se, me, re, sr, ua, ub, cu, si, inv};
  endfunction

  function automatic logic [6:0] pick_op();
    case ($urandom_range(0, 5))
      0: return LW;
      1: return SW;
      2: return RT;
      3: return IT;
      4: return JL;
      default: return BQ;
    endcase
  endfunction

  task automatic apply_reset();
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    cnt_model = 0;
  endtask

  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3,
                           input logic f7, input int zmode);
    int seq[5];
    int n;
    logic [16:0] e;
    seq = '{0, 1, 11, 0, 0};
    n = 3;
    case (op)
      LW: begin seq = '{0, 1, 2, 3, 4}; n = 5; end
      SW: begin seq = '{0, 1, 2, 5, 0}; n = 4; end
      RT: begin seq = '{0, 1, 6, 7, 0}; n = 4; end
      IT: begin seq = '{0, 1, 8, 7, 0}; n = 4; end
      JL: begin seq = '{0, 1, 9, 7, 0}; n = 4; end
      BQ: begin seq = '{0, 1, 10, 0, 0}; n = 3; end
      default: ;
    endcase
    opcode = op; funct3 = f3; funct7_5 = f7;
    for (int i = 0; i < n; i++) begin
      zero = (zmode < 0) ? 1'($urandom_range(0, 1)) : (zmode != 0);
      @(negedge clock);
      if (i == 0) begin
        checks++;
        if (contador_instrucoes !== 32'(cnt_model)) begin
          errors++;
          $display("FAIL counter op=%b got=%0d exp=%0d",
                   op, contador_instrucoes, cnt_model);
        end
        checks++;
        if (w_cnt !== 4'(cnt_model)) begin
          errors++;
          $display("FAIL counter4 op=%b got=%0d exp=%0d",
                   op, w_cnt, 4'(cnt_model));
        end
      end
      checks++;
      if (estado !== 4'(seq[i])) begin
        errors++;
        $display("FAIL state op=%b step=%0d got=%0d exp=%0d",
                 op, i, estado, seq[i]);
      end
      e = expect_out(seq[i], op, f3, f7, zero);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL outputs op=%b st=%0d got=%b exp=%b",
                 op, seq[i], obs, e);
      end
      @(posedge clock); #1;
    end
    if (n != 3 || op == BQ)
      cnt_model++;
  endtask

  task automatic test_reset();
    opcode = 7'($urandom);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    cnt_model = 0;
    @(negedge clock);
    checks++;
    if (estado !== 4'd0 || contador_instrucoes !== 32'd0 ||
        instrucao_invalida !== 1'b0 || w_cnt !== 4'd0) begin
      errors++;
      $display("FAIL reset st=%0d cnt=%0d inv=%b exp 0/0/0",
               estado, contador_instrucoes, instrucao_invalida);
    end
    @(posedge clock); #1;
    apply_reset();
  endtask

  task automatic test_mem();
    run_instr(LW, 3'd2, 1'b0, -1);
    run_instr(SW, 3'd2, 1'b1, -1);
    run_instr(LW, 3'd0, 1'b1, -1);
  endtask

  task automatic test_alu();
    run_instr(RT, 3'd0, 1'b1, -1);
    run_instr(RT, 3'd0, 1'b0, -1);
    run_instr(IT, 3'd0, 1'b1, -1);
    run_instr(RT, 3'd7, 1'b0, -1);
    run_instr(IT, 3'd2, 1'b0, -1);
    run_instr(RT, 3'd6, 1'b1, -1);
    run_instr(IT, 3'd4, 1'b1, -1);
    run_instr(JL, 3'd5, 1'b0, -1);
  endtask

  task automatic test_beq();
    run_instr(BQ, 3'd0, 1'b0, 1);
    run_instr(BQ, 3'd0, 1'b0, 0);
    run_instr(SW, 3'd0, 1'b0, -1);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 40; k++)
      run_instr(pick_op(), 3'($urandom), 1'($urandom), -1);
  endtask

  task automatic test_erro();
    int held;
    apply_reset();
    run_instr(RT, 3'd0, 1'b0, -1);
    held = cnt_model;
    run_instr(BAD, 3'd0, 1'b0, -1);
    for (int k = 0; k < 10; k++) begin
      opcode = 7'($urandom);
      zero = 1'($urandom);
      @(negedge clock);
      checks++;
      if (estado !== 4'd11 || instrucao_invalida !== 1'b1 ||
          {pc_escrita, ir_escrita, mem_escrita, reg_escrita} !== 4'd0 ||
          contador_instrucoes !== 32'(held)) begin
        errors++;
        $display("FAIL erro_hold k=%0d st=%0d inv=%b en=%b cnt=%0d",
                 k, estado, instrucao_invalida,
                 {pc_escrita, ir_escrita, mem_escrita, reg_escrita},
                 contador_instrucoes);
      end
    end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    cnt_model = 0;
    @(negedge clock);
    checks++;
    if (estado !== 4'd0 || instrucao_invalida !== 1'b0) begin
      errors++;
      $display("FAIL erro_reset st=%0d inv=%b exp 0/0",
               estado, instrucao_invalida);
    end
    @(posedge clock); #1;
    apply_reset();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    run_instr(RT, 3'd0, 1'b0, -1);
    run_instr(IT, 3'd0, 1'b0, -1);
    opcode = LW;
    repeat (3) begin
      @(posedge clock); #1;
    end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (estado !== 4'd3) begin
      errors++;
      $display("FAIL mid_state got=%0d exp=3", estado);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    cnt_model = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      checks++;
      if (estado !== 4'(k) || contador_instrucoes !== 32'd0 ||
          reg_escrita !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset k=%0d st=%0d cnt=%0d re=%b",
                 k, estado, contador_instrucoes, reg_escrita);
      end
      @(posedge clock); #1;
    end
    apply_reset();
  endtask

  task automatic test_wrap();
    apply_reset();
    for (int k = 0; k < 16; k++)
      run_instr(pick_op(), 3'($urandom), 1'($urandom), -1);
    @(negedge clock);
    checks++;
    if (w_cnt !== 4'd0 || contador_instrucoes !== 32'd16) begin
      errors++;
      $display("FAIL wrap got4=%0d got32=%0d exp 0/16",
               w_cnt, contador_instrucoes);
    end
    @(posedge clock); #1;
  endtask

  initial begin
    test_reset();
    test_mem();
    test_alu();
    test_beq();
    test_back_to_back();
    test_erro();
    test_reset_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
